// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the Fetch receive side: the fetched word layout,
// the branch opcode, the redirect FSM states and small field helpers.
// ----------------------------------------------------------------------------
package fetch_pkg;

   localparam int WORD_W  = 60;
   localparam int OPC_HI  = 59;
   localparam int OPC_LO  = 52;
   localparam int DIR_BIT = 16;
   localparam int OFF_HI  = 15;
   localparam int OFF_LO  = 0;

   localparam logic [7:0] OP_BR = 8'h10;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_STALL    = 2'd1,
      ST_REDIRECT = 2'd2
   } fq_state_e;

   // True when the word carries the branch opcode.
   function automatic logic is_branch(input logic [WORD_W-1:0] word);
      return (word[OPC_HI:OPC_LO] == OP_BR);
   endfunction

   // 16-bit increment that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] val);
      return (val == 16'hFFFF) ? 16'hFFFF : (val + 16'd1);
   endfunction

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered storage. The head entry is read straight
// out of the storage flops, so a word pushed on one edge is visible on rdata
// (with empty low) right after that edge.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   push, wdata     : write request and data (accepted when not full, or
//                     when a pop happens in the same cycle)
//   pop             : remove head entry (ignored when empty)
//   rdata           : head entry
//   full, empty     : occupancy flags
//   count           : number of stored entries
// ----------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 60,
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [PTR_W:0]   count
);

   localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W:0]   count_r;
   logic             do_pop_s;
   logic             do_push_s;

   assign full  = (count_r == DEPTH_C);
   assign empty = (count_r == '0);
   assign count = count_r;
   assign rdata = mem_r[rd_ptr_r];

   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign do_pop_s  = pop & ~empty;
   assign do_push_s = push & (~full | do_pop_s);

   // Storage, pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
            wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + (PTR_W+1)'(1);
            2'b01:   count_r <= count_r - (PTR_W+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue
// Receive side of the Fetch interface. Every word Fetch presents is taken;
// non-branch words go into a FIFO for Decode, branch words turn into a
// one-cycle redirect, and words that find the FIFO full are dropped and later
// replayed by a backward redirect covering every dropped word.
// Ports:
//   clock_i, reset_i   : clock, synchronous active-high reset
//   data_i, enable_i   : word and valid strobe from Fetch
//   shouldBranch_o     : redirect request to Fetch
//   branchOffset_o     : redirect distance
//   branchDirection_o  : 1 forward, 0 backward
//   flushBack_o        : kills Fetch's in-flight word, pulses with redirect
//   dec_data_o         : head word for Decode
//   dec_valid_o        : FIFO not empty
//   dec_ready_i        : Decode takes the head word
// ----------------------------------------------------------------------------
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic [WORD_W-1:0] data_i,
   input  logic              enable_i,
   output logic              shouldBranch_o,
   output logic [15:0]       branchOffset_o,
   output logic              branchDirection_o,
   output logic              flushBack_o,
   output logic [WORD_W-1:0] dec_data_o,
   output logic              dec_valid_o,
   input  logic              dec_ready_i
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   fq_state_e         state_r;
   fq_state_e         state_s;
   logic [15:0]       off_r;
   logic [15:0]       off_s;
   logic              dir_r;
   logic              dir_s;
   logic [15:0]       drop_cnt_r;
   logic [15:0]       drop_cnt_s;
   logic              push_s;
   logic              pop_s;
   logic              fifo_full_s;
   logic              fifo_empty_s;
   logic [CNT_W-1:0]  fifo_count_s;
   logic              run_space_s;
   logic              stall_space_s;
   logic              sb_r;
   logic [15:0]       boff_r;
   logic              bdir_r;

   assign pop_s       = ~fifo_empty_s & dec_ready_i;
   // A pop in the same cycle frees a slot, in RUN and STALL alike.
   assign run_space_s   = ~fifo_full_s | pop_s;
   assign stall_space_s = (fifo_count_s < DEPTH_C) | pop_s;

   sync_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clock_i),
      .rst   (reset_i),
      .push  (push_s),
      .pop   (pop_s),
      .wdata (data_i),
      .rdata (dec_data_o),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .count (fifo_count_s)
   );

   assign dec_valid_o = ~fifo_empty_s;

   // Next-state, push decision and redirect register updates.
   always_comb begin
      state_s    = state_r;
      off_s      = off_r;
      dir_s      = dir_r;
      drop_cnt_s = drop_cnt_r;
      push_s     = 1'b0;
      case (state_r)
         ST_RUN: begin
            drop_cnt_s = 16'd0;
            if (enable_i) begin
               if (is_branch(data_i)) begin
                  off_s   = data_i[OFF_HI:OFF_LO];
                  dir_s   = data_i[DIR_BIT];
                  state_s = ST_REDIRECT;
               end else if (run_space_s) begin
                  push_s = 1'b1;
               end else begin
                  // First lost word; the replay must step back over it.
                  drop_cnt_s = 16'd1;
                  state_s    = ST_STALL;
               end
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_STALL: begin
            drop_cnt_s = sat_inc16(drop_cnt_r);
            if (stall_space_s) begin
               // The redirect cycle's shadow word is dropped too, hence +1.
               off_s   = sat_inc16(drop_cnt_s);
               dir_s   = 1'b0;
               state_s = ST_REDIRECT;
            end else begin
               state_s = ST_STALL;
            end
         end
         ST_REDIRECT: begin
            drop_cnt_s = 16'd0;
            state_s    = ST_RUN;
         end
         default: begin
            drop_cnt_s = 16'd0;
            state_s    = ST_RUN;
         end
      endcase
   end

   // FSM and redirect register state.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_r    <= ST_RUN;
         off_r      <= 16'd0;
         dir_r      <= 1'b0;
         drop_cnt_r <= 16'd0;
      end else begin
         state_r    <= state_s;
         off_r      <= off_s;
         dir_r      <= dir_s;
         drop_cnt_r <= drop_cnt_s;
      end
   end

   // Redirect outputs, live only in the cycle the FSM sits in REDIRECT.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         sb_r   <= 1'b0;
         boff_r <= 16'd0;
         bdir_r <= 1'b0;
      end else if (state_s == ST_REDIRECT) begin
         sb_r   <= 1'b1;
         boff_r <= off_s;
         bdir_r <= dir_s;
      end else begin
         sb_r   <= 1'b0;
         boff_r <= 16'd0;
         bdir_r <= 1'b0;
      end
   end

   assign shouldBranch_o    = sb_r;
   assign flushBack_o       = sb_r;
   assign branchOffset_o    = boff_r;
   assign branchDirection_o = bdir_r;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

   localparam int DEPTH = 4;

   logic        clock_i = 1'b0;
   logic        reset_i = 1'b1;
   logic [59:0] data_i = '0;
   logic        enable_i = 1'b0;
   logic        shouldBranch_o;
   logic [15:0] branchOffset_o;
   logic        branchDirection_o;
   logic        flushBack_o;
   logic [59:0] dec_data_o;
   logic        dec_valid_o;
   logic        dec_ready_i = 1'b0;

   int checks = 0;
   int errors = 0;

   fetch_queue #(.DEPTH(DEPTH)) dut (
      .clock_i           (clock_i),
      .reset_i           (reset_i),
      .data_i            (data_i),
      .enable_i          (enable_i),
      .shouldBranch_o    (shouldBranch_o),
      .branchOffset_o    (branchOffset_o),
      .branchDirection_o (branchDirection_o),
      .flushBack_o       (flushBack_o),
      .dec_data_o        (dec_data_o),
      .dec_valid_o       (dec_valid_o),
      .dec_ready_i       (dec_ready_i)
   );

   always #5 clock_i = ~clock_i;

   // ---------------- reference model (queue + replay bookkeeping) ----------
   logic [59:0] m_q[$];
   int          m_mode = 0;   // 0 normal, 1 dropping, 2 redirect cycle
   int          m_drop = 0;
   int          m_off  = 0;
   bit          m_dir  = 1'b0;

   function automatic logic [59:0] w(input int n);
      logic [51:0] v;
      v = 52'(n);
      return {8'h01, v};
   endfunction

   function automatic logic [59:0] br(input logic dir, input logic [15:0] off);
      logic [34:0] z;
      z = 35'h0;
      return {8'h10, z, dir, off};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input logic r, input logic e, input logic [59:0] d, input logic rd);
      bit pop, room, push;
      int nxt;
      if (r) begin
         m_q.delete();
         m_mode = 0; m_drop = 0; m_off = 0; m_dir = 1'b0;
      end else begin
         pop  = (m_q.size() > 0) && rd;
         room = (m_q.size() < DEPTH) || pop;
         push = 1'b0;
         nxt  = 0;
         if (m_mode == 0) begin
            m_drop = 0;
            if (e) begin
               if (d[59:52] == 8'h10) begin
                  m_off = int'(d[15:0]); m_dir = d[16]; nxt = 2;
               end else if (room) begin
                  push = 1'b1;
               end else begin
                  m_drop = 1; nxt = 1;
               end
            end
         end else if (m_mode == 1) begin
            m_drop = (m_drop < 65535) ? m_drop + 1 : 65535;
            if (room) begin
               m_off = (m_drop < 65535) ? m_drop + 1 : 65535;
               m_dir = 1'b0;
               nxt = 2;
            end else begin
               nxt = 1;
            end
         end else begin
            m_drop = 0;
            nxt = 0;
         end
         if (pop) void'(m_q.pop_front());
         if (push) m_q.push_back(d);
         m_mode = nxt;
      end
   endtask

   task automatic model_compare();
      bit sb;
      sb = (m_mode == 2);
      chk("m_should_branch", 64'(shouldBranch_o), 64'(sb));
      chk("m_flush_back", 64'(flushBack_o), 64'(sb));
      chk("m_offset", 64'(branchOffset_o), sb ? 64'(m_off) : 64'd0);
      chk("m_direction", 64'(branchDirection_o), sb ? 64'(m_dir) : 64'd0);
      chk("m_dec_valid", 64'(dec_valid_o), 64'(m_q.size() > 0));
      if (m_q.size() > 0) chk("m_dec_data", 64'(dec_data_o), 64'(m_q[0]));
   endtask

   // Drive one cycle, advance the model across the same edge, compare.
   task automatic cycle(input logic r, input logic [59:0] d, input logic rd);
      reset_i = r; enable_i = ~r; data_i = d; dec_ready_i = rd;
      @(posedge clock_i); #1;
      model_step(r, ~r, d, rd);
      model_compare();
   endtask

   // ---------------- directed vector table ---------------------------------
   typedef struct {
      logic        rst;
      logic [59:0] d;
      logic        rdy;
      logic        sb;
      logic [15:0] off;
      logic        dir;
      logic        vld;
      logic [59:0] dat;
   } vec_t;

   vec_t vec[24];

   initial begin
      int rdy_pct;
      vec[0]  = '{1'b1, 60'h0,        1'b1, 1'b0, 16'd0,  1'b0, 1'b0, 60'h0};
      vec[1]  = '{1'b0, w(1),         1'b1, 1'b0, 16'd0,  1'b0, 1'b1, w(1)};
      vec[2]  = '{1'b0, w(2),         1'b1, 1'b0, 16'd0,  1'b0, 1'b1, w(2)};
      vec[3]  = '{1'b0, w(3),         1'b1, 1'b0, 16'd0,  1'b0, 1'b1, w(3)};
      vec[4]  = '{1'b0, br(1'b1,16'd10), 1'b1, 1'b1, 16'd10, 1'b1, 1'b0, 60'h0};
      vec[5]  = '{1'b0, w(4),         1'b1, 1'b0, 16'd0,  1'b0, 1'b0, 60'h0};
      vec[6]  = '{1'b0, w(5),         1'b1, 1'b0, 16'd0,  1'b0, 1'b1, w(5)};
      vec[7]  = '{1'b0, br(1'b0,16'd20), 1'b1, 1'b1, 16'd20, 1'b0, 1'b0, 60'h0};
      vec[8]  = '{1'b0, w(6),         1'b1, 1'b0, 16'd0,  1'b0, 1'b0, 60'h0};
      vec[9]  = '{1'b0, w(7),         1'b1, 1'b0, 16'd0,  1'b0, 1'b1, w(7)};
      vec[10] = '{1'b0, w(8),         1'b0, 1'b0, 16'd0,  1'b0, 1'b1, w(7)};
      vec[11] = '{1'b0, w(9),         1'b0, 1'b0, 16'd0,  1'b0, 1'b1, w(7)};
      vec[12] = '{1'b0, w(10),        1'b0, 1'b0, 16'd0,  1'b0, 1'b1, w(7)};
      vec[13] = '{1'b0, w(11),        1'b1, 1'b0, 16'd0,  1'b0, 1'b1, w(8)};
      vec[14] = '{1'b0, w(12),        1'b0, 1'b0, 16'd0,  1'b0, 1'b1, w(8)};
      vec[15] = '{1'b0, w(13),        1'b1, 1'b1, 16'd3,  1'b0, 1'b1, w(9)};
      vec[16] = '{1'b0, w(14),        1'b0, 1'b0, 16'd0,  1'b0, 1'b1, w(9)};
      vec[17] = '{1'b0, w(12),        1'b0, 1'b0, 16'd0,  1'b0, 1'b1, w(9)};
      vec[18] = '{1'b0, w(15),        1'b0, 1'b0, 16'd0,  1'b0, 1'b1, w(9)};
      vec[19] = '{1'b0, w(16),        1'b0, 1'b0, 16'd0,  1'b0, 1'b1, w(9)};
      vec[20] = '{1'b1, 60'h0,        1'b0, 1'b0, 16'd0,  1'b0, 1'b0, 60'h0};
      vec[21] = '{1'b0, w(17),        1'b0, 1'b0, 16'd0,  1'b0, 1'b1, w(17)};
      vec[22] = '{1'b0, w(18),        1'b1, 1'b0, 16'd0,  1'b0, 1'b1, w(18)};
      vec[23] = '{1'b0, w(19),        1'b1, 1'b0, 16'd0,  1'b0, 1'b1, w(19)};

      for (int i = 0; i < 24; i++) begin
         cycle(vec[i].rst, vec[i].d, vec[i].rdy);
         chk($sformatf("v%0d_should_branch", i), 64'(shouldBranch_o), 64'(vec[i].sb));
         chk($sformatf("v%0d_flush_back", i), 64'(flushBack_o), 64'(vec[i].sb));
         chk($sformatf("v%0d_offset", i), 64'(branchOffset_o), 64'(vec[i].off));
         chk($sformatf("v%0d_direction", i), 64'(branchDirection_o), 64'(vec[i].dir));
         chk($sformatf("v%0d_dec_valid", i), 64'(dec_valid_o), 64'(vec[i].vld));
         if (vec[i].vld || vec[i].rst)
            chk($sformatf("v%0d_dec_data", i), 64'(dec_data_o), 64'(vec[i].dat));
      end

      // A branch word in the redirect shadow is dropped: no back-to-back pulse.
      cycle(1'b0, br(1'b1, 16'd5), 1'b1);
      chk("bb_first_pulse", 64'(shouldBranch_o), 64'd1);
      chk("bb_first_offset", 64'(branchOffset_o), 64'd5);
      cycle(1'b0, br(1'b0, 16'd7), 1'b1);
      chk("bb_shadow_no_pulse", 64'(shouldBranch_o), 64'd0);
      cycle(1'b0, w(20), 1'b1);
      chk("bb_after_valid", 64'(dec_valid_o), 64'd1);
      chk("bb_after_data", 64'(dec_data_o), 64'(w(20)));

      // Randomised traffic with varying backpressure.
      for (int n = 0; n < 3000; n++) begin
         logic [59:0] d;
         logic [7:0]  opc;
         logic        r;
         rdy_pct = (n / 500 % 3 == 0) ? 20 : ((n / 500 % 3 == 1) ? 50 : 90);
         r = ($urandom_range(0, 149) == 0);
         if ($urandom_range(0, 7) == 0) begin
            d = br(1'($urandom_range(0, 1)), 16'($urandom()));
         end else begin
            opc = 8'($urandom_range(0, 255));
            if (opc == 8'h10) opc = 8'h11;
            d = {opc, 20'($urandom()), 32'($urandom())};
         end
         cycle(r, d, ($urandom_range(0, 99) < rdy_pct));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
